seq_pattern_gen: RTL and testbench

//   Moore-FSM serial pattern transmitter: the source end of the serial sequence-detector link.
//   - On a start request, latches a PAT_W-bit pattern (default use 4'b1001).
//   - Shifts the pattern out MSB-first, one bit per clk, repeat_n times.
//   - Generates stimulus streams for the detector FSMs and drives serial lines in higher-level designs.

---
 rtl/seq_pattern_gen.sv | 150 +++++++++++++++
 tb/tb_seq_pattern_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial pattern transmitter for the sequence-detector link.
// Latches a PAT_W-bit pattern on start and shifts it out MSB-first,
// max(repeat_n,1) times. Build option SEQ_GEN_GAP_EN inserts GAP idle
// cycles (out=0, valid=0, busy=1) between consecutive frames; without it,
// frames are sent back-to-back and the GAP parameter has no effect.
//
// state | meaning
// IDLE  | waiting for start; outputs low
// SHIFT | driving pattern bits, valid=1, busy=1
// GAP   | inter-frame idle, out=0, valid=0, busy=1 (SEQ_GEN_GAP_EN only)
// DONE  | one-cycle done pulse, then back to IDLE
module seq_pattern_gen #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 4,
   parameter int GAP   = 2
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_n,
   output logic             out,
   output logic             valid,
   output logic             busy,
   output logic             done
);

   localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);

   // Reject parameter values the datapath cannot honour.
   if (PAT_W < 2 || GAP < 1) begin : g_bad_param
      $error("seq_pattern_gen: PAT_W must be >= 2 and GAP >= 1");
   end

`ifdef SEQ_GEN_GAP_EN
   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP, ST_DONE} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
`endif

   state_t             state, state_next;
   logic [PAT_W-1:0]   shreg, shreg_next;
   logic [PAT_W-1:0]   pat_q, pat_next;
   logic [CNT_W-1:0]   frames, frames_next;
   logic [BIT_W-1:0]   bitcnt, bitcnt_next;
   logic               out_next, valid_next, busy_next, done_next;
`ifdef SEQ_GEN_GAP_EN
   logic [GAP_W-1:0]   gapcnt, gapcnt_next;
`endif

   // State, datapath and registered outputs.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state  <= ST_IDLE;
         shreg  <= '0;
         pat_q  <= '0;
         frames <= '0;
         bitcnt <= '0;
`ifdef SEQ_GEN_GAP_EN
         gapcnt <= '0;
`endif
         out    <= 1'b0;
         valid  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_next;
         shreg  <= shreg_next;
         pat_q  <= pat_next;
         frames <= frames_next;
         bitcnt <= bitcnt_next;
`ifdef SEQ_GEN_GAP_EN
         gapcnt <= gapcnt_next;
`endif
         out    <= out_next;
         valid  <= valid_next;
         busy   <= busy_next;
         done   <= done_next;
      end
   end

   // Next-state, datapath update, and output values for the next cycle.
   always_comb begin
      state_next  = state;
      shreg_next  = shreg;
      pat_next    = pat_q;
      frames_next = frames;
      bitcnt_next = bitcnt;
`ifdef SEQ_GEN_GAP_EN
      gapcnt_next = gapcnt;
`endif
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_next  = ST_SHIFT;
               shreg_next  = pattern;
               pat_next    = pattern;
               frames_next = (repeat_n == '0) ? CNT_W'(1) : repeat_n;
               bitcnt_next = '0;
            end
         end
         ST_SHIFT: begin
            shreg_next  = shreg << 1;
            bitcnt_next = bitcnt + BIT_W'(1);
            if (bitcnt == BIT_LAST) begin
               bitcnt_next = '0;
               if (frames > CNT_W'(1)) begin
                  frames_next = frames - CNT_W'(1);
                  shreg_next  = pat_q;
`ifdef SEQ_GEN_GAP_EN
                  state_next  = ST_GAP;
                  gapcnt_next = GAP_W'(GAP - 1);
`endif
               end else begin
                  state_next = ST_DONE;
               end
            end
         end
`ifdef SEQ_GEN_GAP_EN
         ST_GAP: begin
            if (gapcnt == '0) begin
               state_next = ST_SHIFT;
            end else begin
               gapcnt_next = gapcnt - GAP_W'(1);
            end
         end
`endif
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // Outputs are decoded from the state being entered so they appear as
      // flops aligned with that state.
      valid_next = (state_next == ST_SHIFT);
      out_next   = valid_next & shreg_next[PAT_W-1];
      done_next  = (state_next == ST_DONE);
`ifdef SEQ_GEN_GAP_EN
      busy_next  = (state_next == ST_SHIFT) || (state_next == ST_GAP);
`else
      busy_next  = (state_next == ST_SHIFT);
`endif
   end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: stimulus pushes expected bits and
// done markers; a negedge monitor pops and compares whenever valid or done
// is presented. Works with and without SEQ_GEN_GAP_EN.
module tb_seq_pattern_gen;

`ifdef SEQ_GEN_GAP_EN
   localparam int GAPC = 2;
`else
   localparam int GAPC = 0;
`endif

   logic       clk = 1'b0;
   logic       clear_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] pattern = 4'b0000;
   logic [3:0] repeat_n = 4'd0;
   logic       out, valid, busy, done;

   seq_pattern_gen #(.PAT_W(4), .CNT_W(4), .GAP(2)) dut (
      .clk(clk), .clear_n(clear_n), .start(start), .pattern(pattern),
      .repeat_n(repeat_n), .out(out), .valid(valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct { bit is_done; bit val; } exp_t;
   exp_t q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int busy_tot = 0, gapv_tot = 0, done_tot = 0, det_tot = 0;
   int rise_cyc = -1, done_cyc = -1, det_cyc = -1;
   int k_edge = 0;
   logic valid_d = 1'b0;

   // 1001 non-overlapping detector fed from out (loopback model).
   logic [2:0] hist;
   logic       det;
   always @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         hist <= 3'b000;
         det  <= 1'b0;
      end else begin
         det  <= ({hist, out} == 4'b1001);
         hist <= ({hist, out} == 4'b1001) ? 3'b000 : {hist[1:0], out};
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a bit or done.
   always @(negedge clk) begin
      exp_t e;
      if (busy === 1'b1) busy_tot++;
      if (busy === 1'b1 && valid !== 1'b1) gapv_tot++;
      if (valid === 1'b1 && valid_d !== 1'b1) rise_cyc = cyc;
      valid_d = valid;
      if (valid === 1'b1) begin
         if (q.size() == 0) chk("unexpected_bit", 1, 0);
         else begin
            e = q.pop_front();
            chk("out_bit", {30'd0, 1'b0, out}, {30'd0, e.is_done, e.val});
         end
      end
      if (done === 1'b1) begin
         done_tot++;
         done_cyc = cyc;
         if (q.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            e = q.pop_front();
            chk("done_order", 1, {31'd0, e.is_done});
         end
      end
      if (det === 1'b1) begin
         det_tot++;
         det_cyc = cyc;
      end
   end

   task automatic push_frames(input logic [3:0] pat, input int frames);
      for (int f = 0; f < frames; f++)
         for (int i = 3; i >= 0; i--) q.push_back('{is_done: 1'b0, val: pat[i]});
      q.push_back('{is_done: 1'b1, val: 1'b0});
   endtask

   task automatic pulse_start(input logic [3:0] pat, input logic [3:0] rep);
      pattern  = pat;
      repeat_n = rep;
      start    = 1'b1;
      @(posedge clk);
      #1;
      k_edge = cyc;
      start  = 1'b0;
   endtask

   task automatic wait_done(input int prev);
      int n = 0;
      while (done_tot <= prev && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (done_tot <= prev) chk("done_timeout", 0, 1);
   endtask

   task automatic run_check(input logic [3:0] pat, input logic [3:0] rep,
                            input int exp_busy, input int exp_gap);
      int b0 = busy_tot;
      int g0 = gapv_tot;
      int d0 = done_tot;
      push_frames(pat, (rep == 0) ? 1 : int'(rep));
      pulse_start(pat, rep);
      wait_done(d0);
      chk("first_bit_latency", rise_cyc, k_edge);
      chk("done_cycle", done_cyc, k_edge + exp_busy);
      chk("busy_cycles", busy_tot - b0, exp_busy);
      chk("gap_cycles", gapv_tot - g0, exp_gap);
      @(posedge clk);
      #1;
      chk("idle_busy", {31'd0, busy}, 0);
      chk("idle_done", {31'd0, done}, 0);
      chk("queue_drained", q.size(), 0);
   endtask

   initial begin
      int d0, d1, det0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out", {31'd0, out}, 0);
      chk("rst_valid", {31'd0, valid}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      clear_n = 1'b1;
      @(posedge clk);
      #1;

      // Single frame 1001.
      run_check(4'b1001, 4'd1, 4, 0);
      // Three frames, contiguous or separated by gaps.
      run_check(4'b1001, 4'd3, 12 + 2 * GAPC, 2 * GAPC);
      // Different pattern, two frames.
      run_check(4'b1100, 4'd2, 8 + GAPC, GAPC);

      // repeat_n=0 sends one frame; mid-frame restart and pattern change ignored.
      d0 = done_tot;
      push_frames(4'b1001, 1);
      pulse_start(4'b1001, 4'd0);
      @(negedge clk);
      #1;
      pattern  = 4'b0110;
      repeat_n = 4'd5;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(d0);
      chk("rep0_done_cycle", done_cyc, k_edge + 4);
      repeat (4) @(posedge clk);
      #1;
      chk("no_restart_done", done_tot, d0 + 1);
      chk("no_restart_busy", {31'd0, busy}, 0);

      // start held high restarts in the IDLE cycle after DONE.
      d0 = done_tot;
      push_frames(4'b1001, 1);
      push_frames(4'b1001, 1);
      pulse_start(4'b1001, 4'd1);
      start = 1'b1;
      wait_done(d0);
      d1 = done_cyc;
      @(posedge clk);
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(d0 + 1);
      chk("held_start_restart", rise_cyc, d1 + 2);
      chk("held_start_dones", done_tot, d0 + 2);
      @(posedge clk);
      #1;

      // Reset during bit 2 aborts without done.
      d0 = done_tot;
      q.push_back('{is_done: 1'b0, val: 1'b1});
      q.push_back('{is_done: 1'b0, val: 1'b0});
      pulse_start(4'b1001, 4'd1);
      @(negedge clk);
      @(negedge clk);
      #1;
      clear_n = 1'b0;
      #1;
      chk("abort_out", {31'd0, out}, 0);
      chk("abort_valid", {31'd0, valid}, 0);
      chk("abort_busy", {31'd0, busy}, 0);
      repeat (2) @(posedge clk);
      #1;
      clear_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("abort_no_done", done_tot, d0);
      chk("abort_queue", q.size(), 0);
      run_check(4'b1001, 4'd1, 4, 0);

      // Loopback into the 1001 detector, two frames.
      det0 = det_tot;
      run_check(4'b1001, 4'd2, 8 + GAPC, GAPC);
      chk("loop_det_count", det_tot - det0, 2);
      chk("loop_det_timing", det_cyc, done_cyc);

      repeat (3) @(posedge clk);
      chk("final_queue", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
